// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial_tx UART transmitter and its sub-modules.
// Contents:
//   tx_state_e  FSM state encoding (IDLE, START, DATA, STOP)
//   DATA_BITS   payload bits per frame (8N1)
//   baud_clks() clock cycles per bit, CLK_FREQ / BAUD_RATE truncated
package serial_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int DATA_BITS = 8;

  // The result must be >= 2; smaller ratios leave no room for the counter
  // to reload and tick.
  function automatic int baud_clks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/serial_tx_baud_timer.sv
// Bit-period timer for the UART transmitter.
// A down-counter that reloads to BAUD_CLKS-1 on i_restart or when it reaches
// zero, and pulses o_tick for one cycle while it sits at zero. A restart
// therefore yields the first tick exactly BAUD_CLKS cycles later, and
// free-running operation ticks every BAUD_CLKS cycles.
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous reset, active-low (counter cleared)
//   i_restart  reload the counter on the next edge
//   o_tick     one-cycle pulse at the end of each bit period
module baud_timer
  import serial_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int BAUD_CLKS = baud_clks(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W     = $clog2(BAUD_CLKS);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(BAUD_CLKS - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_restart || count == '0) begin
      count <= RELOAD;
    end else begin
      count <= count - CNT_W'(1);
    end
  end

  assign o_tick = (count == '0);

endmodule

// File: rtl/serial_tx.sv
// UART transmitter, 8N1, LSB first.
// A byte written with i_wr lands in a one-byte holding register; the FSM moves
// it into the shifter when idle, or straight at the end of a stop bit so that
// back-to-back frames leave no idle gap. o_tx is registered from the current
// FSM state, so the line lags the state by one cycle throughout.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous reset, active-low; aborts any frame, o_tx forced high
//   i_wr     write strobe, accepted on an edge when i_wr && !o_full
//   i_data   byte to send, sampled with i_wr
//   o_full   holding register occupied; writes dropped while high
//   o_busy   frame in progress (FSM not IDLE)
//   o_tx     serial line, idle high
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic       o_busy,
  output logic       o_tx
);

  tx_state_e  state, state_next;
  logic [7:0] hold;
  logic [7:0] shift, shift_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic       load;
  logic       restart;
  logic       tick;
  logic       accept;
  logic       tx_next;

  baud_timer #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_restart (restart),
    .o_tick    (tick)
  );

  // Acceptance looks only at the registered o_full, so a write on the very
  // edge the holding register empties is still dropped.
  assign accept = i_wr && !o_full;

  // NOTE: every output of a combinational block gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    load         = 1'b0;
    restart      = 1'b0;
    tx_next      = 1'b1;

    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (o_full) begin
          load       = 1'b1;
          restart    = 1'b1;  // align the bit period to the start of the frame
          state_next = ST_START;
        end
      end
      ST_START: begin
        tx_next = 1'b0;
        if (tick) begin
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        tx_next = shift[0];
        if (tick) begin
          shift_next   = shift >> 1;
          bit_idx_next = bit_idx + 3'd1;  // wraps 7 -> 0 on the way to STOP
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_next = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        tx_next = 1'b1;
        if (tick) begin
          // The timer reloads itself at zero, so chaining into START needs no
          // restart and the next frame follows with no idle cycle.
          if (o_full) begin
            load       = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (load) begin
      shift_next = hold;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= ST_IDLE;
      bit_idx <= '0;
      o_full  <= 1'b0;
      o_tx    <= 1'b1;
    end else begin
      state   <= state_next;
      bit_idx <= bit_idx_next;
      o_tx    <= tx_next;
      if (load) begin
        o_full <= 1'b0;
      end else if (accept) begin
        o_full <= 1'b1;
      end
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are only
  // consumed once o_full or the FSM says they are valid.
  always_ff @(posedge i_clk) begin
    shift <= shift_next;
    if (accept) begin
      hold <= i_data;
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx at 500 kHz / 115200 baud (4 clocks per bit).
// The reference model works at frame level: a frame is 10*B cycles long and
// the line value at any point is bit (position / B) of {start, data LSB first,
// stop}. A software receiver decodes the sampled line back into bytes.
module tb_serial_tx;

  localparam int CLK_FREQ  = 500_000;
  localparam int BAUD_RATE = 115_200;
  localparam int B         = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = 10 * B;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr    = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       full;
  logic       busy;
  logic       tx;

  serial_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_wr    (wr),
    .i_data  (data),
    .o_full  (full),
    .o_busy  (busy),
    .o_tx    (tx)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         m_active;
  bit         m_full;
  int         m_pos;
  logic [7:0] m_byte;
  logic [7:0] m_hold;
  logic       m_tx;
  logic [7:0] sent_q[$];
  logic       line_q[$];
  logic [7:0] rx_q[$];

  function automatic logic line_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_full   = 1'b0;
    m_pos    = 0;
    m_tx     = 1'b1;
  endtask

  task automatic model_edge(input logic w, input logic [7:0] d);
    bit accept_m, ending, load_m;
    accept_m = w && !m_full;
    ending   = m_active && (m_pos == FRAME - 1);
    load_m   = m_full && (!m_active || ending);
    m_tx     = m_active ? line_bit(m_byte, m_pos / B) : 1'b1;
    if (load_m) begin
      m_byte   = m_hold;
      m_active = 1'b1;
      m_pos    = 0;
      m_full   = 1'b0;
      sent_q.push_back(m_hold);
    end else if (ending) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_pos++;
    end
    if (accept_m) begin
      m_hold = d;
      m_full = 1'b1;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, sample at negedge.
  task automatic tick(input logic w, input logic [7:0] d);
    wr   = w;
    data = d;
    @(posedge clk);
    model_edge(w, d);
    @(negedge clk);
    line_q.push_back(tx);
    wr = 1'b0;
  endtask

  task automatic decode_line();
    int i;
    int c;
    logic [7:0] b;
    rx_q.delete();
    i = 1;
    while (i < line_q.size()) begin
      if (line_q[i-1] === 1'b1 && line_q[i] === 1'b0 && (i + B/2 + 9*B) < line_q.size()) begin
        c = i + B/2;
        for (int k = 0; k < 8; k++) b[k] = line_q[c + (k+1)*B];
        if (line_q[c] === 1'b0 && line_q[c + 9*B] === 1'b1) rx_q.push_back(b);
        i = c + 9*B + 1;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, full} !== 3'b100) begin
      errors++;
      $display("FAIL reset_held tx/busy/full got=%b%b%b want=100", tx, busy, full);
    end
    rst_n = 1'b1;
    model_reset();
    tick(1'b0, 8'h00);
    checks++;
    if ({tx, busy, full} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release tx/busy/full got=%b%b%b want=100", tx, busy, full);
    end
  endtask

  task automatic test_idle();
    for (int j = 0; j < 200; j++) begin
      tick(1'b0, 8'h00);
      checks++;
      if ({tx, busy, full} !== 3'b100) begin
        errors++;
        $display("FAIL idle cycle=%0d tx/busy/full got=%b%b%b want=100", j, tx, busy, full);
      end
    end
  endtask

  task automatic test_single_byte();
    logic pat [10];
    int   busy_cycles;
    pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    busy_cycles = 0;
    line_q.delete();
    tick(1'b1, 8'h4B);
    for (int j = 1; j < 60; j++) begin
      tick(1'b0, 8'h00);
      if (busy === 1'b1) busy_cycles++;
      if (j >= 2 && j <= 41) begin
        checks++;
        if (tx !== pat[(j-2)/B]) begin
          errors++;
          $display("FAIL single_wave cycle=%0d tx got=%b want=%b", j, tx, pat[(j-2)/B]);
        end
      end
      checks++;
      if ({tx, busy, full} !== {m_tx, m_active, m_full}) begin
        errors++;
        $display("FAIL single_model cycle=%0d tx/busy/full got=%b%b%b want=%b%b%b",
                 j, tx, busy, full, m_tx, m_active, m_full);
      end
    end
    checks++;
    if (busy_cycles != 40) begin
      errors++;
      $display("FAIL single_busy_len got=%0d want=40", busy_cycles);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [4];
    bytes = '{8'h4B, 8'h00, 8'hFF, 8'h55};
    for (int n = 0; n < 4; n++) begin
      line_q.delete();
      tick(1'b1, bytes[n]);
      for (int j = 0; j < 50; j++) begin
        tick(1'b0, 8'h00);
        checks++;
        if ({tx, busy, full} !== {m_tx, m_active, m_full}) begin
          errors++;
          $display("FAIL loop_model byte=%02h cycle=%0d got=%b%b%b want=%b%b%b",
                   bytes[n], j, tx, busy, full, m_tx, m_active, m_full);
        end
      end
      decode_line();
      checks++;
      if (rx_q.size() != 1 || rx_q[0] !== bytes[n]) begin
        errors++;
        $display("FAIL loopback count=%0d first=%02h want one byte %02h",
                 rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, bytes[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   first_busy, last_busy, nbusy, full_fall;
    logic prev_full;
    first_busy = -1; last_busy = -1; nbusy = 0; full_fall = -1;
    line_q.delete();
    prev_full = full;
    for (int j = 0; j < 100; j++) begin
      if (j == 0)      tick(1'b1, 8'h55);
      else if (j == 6) tick(1'b1, 8'hAA);
      else             tick(1'b0, 8'h00);
      if (busy === 1'b1) begin
        if (first_busy < 0) first_busy = j;
        last_busy = j;
        nbusy++;
      end
      if (j > 6 && prev_full === 1'b1 && full === 1'b0 && full_fall < 0) full_fall = j;
      prev_full = full;
      checks++;
      if ({tx, busy, full} !== {m_tx, m_active, m_full}) begin
        errors++;
        $display("FAIL b2b_model cycle=%0d got=%b%b%b want=%b%b%b",
                 j, tx, busy, full, m_tx, m_active, m_full);
      end
    end
    checks++;
    if (nbusy != 80 || (last_busy - first_busy + 1) != 80) begin
      errors++;
      $display("FAIL b2b_contiguous busy=%0d span=%0d want 80/80", nbusy, last_busy - first_busy + 1);
    end
    checks++;
    if (full_fall != first_busy + FRAME) begin
      errors++;
      $display("FAIL b2b_full_clear cycle got=%0d want=%0d", full_fall, first_busy + FRAME);
    end
    decode_line();
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'hAA) begin
      errors++;
      $display("FAIL b2b_bytes count=%0d want 55 then AA", rx_q.size());
    end
  endtask

  task automatic test_overrun();
    line_q.delete();
    tick(1'b1, 8'h01);
    tick(1'b0, 8'h00);          // 0x01 moves into the shifter here
    tick(1'b1, 8'h02);          // fills the holding register while busy
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL overrun_full_before_03 got=%b want=1", full);
    end
    tick(1'b1, 8'h03);          // must be dropped
    for (int j = 0; j < 100; j++) begin
      tick(1'b0, 8'h00);
      checks++;
      if ({tx, busy, full} !== {m_tx, m_active, m_full}) begin
        errors++;
        $display("FAIL overrun_model cycle=%0d got=%b%b%b want=%b%b%b",
                 j, tx, busy, full, m_tx, m_active, m_full);
      end
    end
    decode_line();
    checks++;
    if (rx_q.size() != 2 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02) begin
      errors++;
      $display("FAIL overrun_bytes count=%0d want 01 then 02", rx_q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int guard;
    line_q.delete();
    tick(1'b1, 8'h4B);
    for (int j = 0; j < 4; j++) tick(1'b0, 8'h00);
    tick(1'b1, 8'h99);          // held byte that the reset must discard
    guard = 0;
    while (!(m_active && (m_pos / B) == 4) && guard < 60) begin
      tick(1'b0, 8'h00);
      guard++;
    end
    checks++;
    if (guard >= 60 || full !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup guard=%0d busy=%b full=%b want busy=1 full=1", guard, busy, full);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tx, busy, full} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid_async got=%b%b%b want=100", tx, busy, full);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx, busy, full} !== 3'b100) begin
      errors++;
      $display("FAIL rst_mid_hold got=%b%b%b want=100", tx, busy, full);
    end
    rst_n = 1'b1;
    line_q.delete();
    tick(1'b1, 8'h4B);
    for (int j = 0; j < 60; j++) begin
      tick(1'b0, 8'h00);
      checks++;
      if ({tx, busy, full} !== {m_tx, m_active, m_full}) begin
        errors++;
        $display("FAIL rst_mid_resend cycle=%0d got=%b%b%b want=%b%b%b",
                 j, tx, busy, full, m_tx, m_active, m_full);
      end
    end
    decode_line();
    checks++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h4B) begin
      errors++;
      $display("FAIL rst_mid_bytes count=%0d want single 4B", rx_q.size());
    end
  endtask

  task automatic test_random();
    logic       w;
    logic [7:0] d;
    int         bad;
    line_q.delete();
    sent_q.delete();
    bad = 0;
    for (int j = 0; j < 3000; j++) begin
      w = ($urandom_range(0, 24) == 0);
      d = 8'($urandom);
      tick(w, d);
      checks++;
      if ({tx, busy, full} !== {m_tx, m_active, m_full}) begin
        errors++;
        if (bad < 10) $display("FAIL random_model cycle=%0d got=%b%b%b want=%b%b%b",
                               j, tx, busy, full, m_tx, m_active, m_full);
        bad++;
      end
    end
    for (int j = 0; j < 120; j++) tick(1'b0, 8'h00);
    decode_line();
    checks++;
    if (rx_q.size() != sent_q.size()) begin
      errors++;
      $display("FAIL random_count got=%0d want=%0d", rx_q.size(), sent_q.size());
    end else begin
      for (int k = 0; k < rx_q.size(); k++) begin
        checks++;
        if (rx_q[k] !== sent_q[k]) begin
          errors++;
          $display("FAIL random_byte idx=%0d got=%02h want=%02h", k, rx_q[k], sent_q[k]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle();
    test_single_byte();
    test_loopback();
    test_back_to_back();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
